// File: rtl/uart_transmitter_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_transmitter_controller_pkg
// Brief    : Shared types and constants for the UART transmitter controller.
// Revision : 1.0 - initial release
// ============================================================================
package uart_transmitter_controller_pkg;

    // Default payload width of one UART frame
    localparam int c_DATA_WIDTH_DEFAULT = 8;

    // Transmit sequencing states (3-bit encoding)
    typedef enum logic [2:0] {
        IDLE          = 3'd0,
        ALU_LOW_SEND  = 3'd1,
        ALU_LOW_WAIT  = 3'd2,
        ALU_HIGH_SEND = 3'd3,
        ALU_HIGH_WAIT = 3'd4,
        READ_SEND     = 3'd5,
        READ_WAIT     = 3'd6
    } tx_state_t;

endpackage : uart_transmitter_controller_pkg
`default_nettype wire

// File: rtl/uart_tx_done_detect.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_done_detect
// Brief    : Flags the end of a transmitter frame: busy was high on the
//            previous cycle (pulse-generator Q) and is low now.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_done_detect (
    input  logic i_busy_sync,
    input  logic i_busy_q,
    output logic o_frame_done
);

    // Falling edge of the synchronised busy flag
    assign o_frame_done = i_busy_q & ~i_busy_sync;

endmodule : uart_tx_done_detect
`default_nettype wire

// File: rtl/uart_transmitter_controller.sv
`default_nettype none
// ============================================================================
// Module   : uart_transmitter_controller
// Brief    : Serialises ALU results (two bytes, low first) and register-file
//            read data (one byte) into the UART transmitter, and gates the
//            UART receiver controller while a sequence is in progress.
// Revision : 1.0 - initial release
// ============================================================================
module uart_transmitter_controller
    import uart_transmitter_controller_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH_DEFAULT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ALU_result_valid,
    input  logic [2*DATA_WIDTH-1:0] ALU_result,
    input  logic                    read_data_valid,
    input  logic [DATA_WIDTH-1:0]   read_data,
    input  logic                    transmitter_busy_synchronized,
    input  logic                    transmitter_Q_pulse_generator,
    output logic [DATA_WIDTH-1:0]   transmitter_parallel_data,
    output logic                    transmitter_parallel_data_valid,
    output logic                    UART_receiver_controller_enable
);

    tx_state_t                 r_state;
    logic [2*DATA_WIDTH-1:0]   r_captured;
    logic [DATA_WIDTH-1:0]     r_tx_data;
    logic                      r_tx_valid;
    logic                      r_rx_enable;
    logic                      w_frame_done;

    uart_tx_done_detect u_done_detect (
        .i_busy_sync  (transmitter_busy_synchronized),
        .i_busy_q     (transmitter_Q_pulse_generator),
        .o_frame_done (w_frame_done)
    );

    // Sequencing FSM; every output is registered and changes with the state.
    // Transmit data only changes on a load, so it stays stable through SEND
    // and WAIT and keeps the last byte sent while idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_captured  <= '0;
            r_tx_data   <= '0;
            r_tx_valid  <= 1'b0;
            r_rx_enable <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (ALU_result_valid) begin
                        r_captured  <= ALU_result;
                        r_tx_data   <= ALU_result[DATA_WIDTH-1:0];
                        r_tx_valid  <= 1'b1;
                        r_rx_enable <= 1'b0;
                        r_state     <= ALU_LOW_SEND;
                    end else if (read_data_valid) begin
                        r_captured  <= {{DATA_WIDTH{1'b0}}, read_data};
                        r_tx_data   <= read_data;
                        r_tx_valid  <= 1'b1;
                        r_rx_enable <= 1'b0;
                        r_state     <= READ_SEND;
                    end
                end
                // Hold the request until the slow-domain transmitter reports busy
                ALU_LOW_SEND: begin
                    if (transmitter_busy_synchronized) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= ALU_LOW_WAIT;
                    end
                end
                ALU_LOW_WAIT: begin
                    if (w_frame_done) begin
                        r_tx_data  <= r_captured[2*DATA_WIDTH-1:DATA_WIDTH];
                        r_tx_valid <= 1'b1;
                        r_state    <= ALU_HIGH_SEND;
                    end
                end
                ALU_HIGH_SEND: begin
                    if (transmitter_busy_synchronized) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= ALU_HIGH_WAIT;
                    end
                end
                ALU_HIGH_WAIT: begin
                    if (w_frame_done) begin
                        r_rx_enable <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                READ_SEND: begin
                    if (transmitter_busy_synchronized) begin
                        r_tx_valid <= 1'b0;
                        r_state    <= READ_WAIT;
                    end
                end
                READ_WAIT: begin
                    if (w_frame_done) begin
                        r_rx_enable <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_tx_valid  <= 1'b0;
                    r_rx_enable <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign transmitter_parallel_data       = r_tx_data;
    assign transmitter_parallel_data_valid = r_tx_valid;
    assign UART_receiver_controller_enable = r_rx_enable;

endmodule : uart_transmitter_controller
`default_nettype wire

// File: tb/tb_uart_transmitter_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_transmitter_controller
// Brief    : Directed self-checking bench for uart_transmitter_controller.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_transmitter_controller;

    localparam int c_W = 8;

    logic             clk;
    logic             reset;
    logic             alu_valid;
    logic [2*c_W-1:0] alu_result;
    logic             rd_valid;
    logic [c_W-1:0]   rd_data;
    logic             busy;
    logic             busy_q;
    logic [c_W-1:0]   tx_data;
    logic             tx_valid;
    logic             rx_enable;

    int checks;
    int errors;

    uart_transmitter_controller #(.DATA_WIDTH(c_W)) dut (
        .clk                             (clk),
        .reset                           (reset),
        .ALU_result_valid                (alu_valid),
        .ALU_result                      (alu_result),
        .read_data_valid                 (rd_valid),
        .read_data                       (rd_data),
        .transmitter_busy_synchronized   (busy),
        .transmitter_Q_pulse_generator   (busy_q),
        .transmitter_parallel_data       (tx_data),
        .transmitter_parallel_data_valid (tx_valid),
        .UART_receiver_controller_enable (rx_enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle past the edge
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // data / valid / enable in one call
    task automatic check_out(input string tag, input logic [7:0] d, input logic v, input logic en);
        check({tag, " data"},   {8'h00, tx_data},  {8'h00, d});
        check({tag, " valid"},  {15'h0, tx_valid}, {15'h0, v});
        check({tag, " enable"}, {15'h0, rx_enable}, {15'h0, en});
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        reset      = 1'b1;
        alu_valid  = 1'b0;
        alu_result = '0;
        rd_valid   = 1'b0;
        rd_data    = '0;
        busy       = 1'b0;
        busy_q     = 1'b0;

        // Reset
        step(2);
        check_out("reset", 8'h00, 1'b0, 1'b1);
        reset = 1'b0;
        step();
        check_out("idle", 8'h00, 1'b0, 1'b1);

        // ALU two-byte send
        alu_result = 16'hE7A6;
        alu_valid  = 1'b1;
        step();
        check_out("alu_low_send", 8'hA6, 1'b1, 1'b0);
        alu_valid = 1'b0;
        step(3);
        check_out("alu_low_hold", 8'hA6, 1'b1, 1'b0);
        busy = 1'b1; busy_q = 1'b1;
        step();
        check_out("alu_low_wait", 8'hA6, 1'b0, 1'b0);
        // missed edge: busy low with Q low must not advance
        busy = 1'b0; busy_q = 1'b0;
        step(2);
        check_out("missed_edge", 8'hA6, 1'b0, 1'b0);
        busy_q = 1'b1;
        step();
        check_out("alu_high_send", 8'hE7, 1'b1, 1'b0);
        busy_q = 1'b0;
        step();
        check_out("alu_high_hold", 8'hE7, 1'b1, 1'b0);
        busy = 1'b1; busy_q = 1'b1;
        step(2);
        check_out("alu_high_wait", 8'hE7, 1'b0, 1'b0);
        busy = 1'b0;
        step();
        check_out("alu_done_idle", 8'hE7, 1'b0, 1'b1);
        busy_q = 1'b0;

        // Read send
        rd_data  = 8'h79;
        rd_valid = 1'b1;
        step();
        check_out("read_send", 8'h79, 1'b1, 1'b0);
        rd_valid = 1'b0;
        rd_data  = 8'h11;
        busy = 1'b1; busy_q = 1'b1;
        step();
        check_out("read_wait", 8'h79, 1'b0, 1'b0);
        busy = 1'b0;
        step();
        check_out("read_done_idle", 8'h79, 1'b0, 1'b1);
        busy_q = 1'b0;

        // Priority and capture: both valids high, ALU wins
        alu_result = 16'h1234;
        alu_valid  = 1'b1;
        rd_data    = 8'h5A;
        rd_valid   = 1'b1;
        step();
        check_out("prio_alu_low", 8'h34, 1'b1, 1'b0);
        alu_valid = 1'b0;
        busy = 1'b1; busy_q = 1'b1;
        step();
        check_out("prio_low_wait", 8'h34, 1'b0, 1'b0);
        alu_result = 16'hFFFF;
        busy = 1'b0;
        step();
        check_out("captured_high", 8'h12, 1'b1, 1'b0);
        busy = 1'b1;
        step();
        check_out("prio_high_wait", 8'h12, 1'b0, 1'b0);
        busy = 1'b0;
        step();
        check_out("prio_idle", 8'h12, 1'b0, 1'b1);
        busy_q = 1'b0;
        // read valid still high starts the deferred read
        step();
        check_out("deferred_read", 8'h5A, 1'b1, 1'b0);
        rd_valid = 1'b0;
        busy = 1'b1; busy_q = 1'b1;
        step();
        busy = 1'b0;
        step();
        check_out("deferred_done", 8'h5A, 1'b0, 1'b1);
        busy_q = 1'b0;

        // Reset in ALU_HIGH_SEND
        alu_result = 16'hBEEF;
        alu_valid  = 1'b1;
        step();
        alu_valid = 1'b0;
        busy = 1'b1; busy_q = 1'b1;
        step();
        busy = 1'b0;
        step();
        check_out("pre_reset_high", 8'hBE, 1'b1, 1'b0);
        reset  = 1'b1;
        busy_q = 1'b0;
        step();
        check_out("mid_reset", 8'h00, 1'b0, 1'b1);
        reset = 1'b0;
        step(2);
        check_out("post_reset_idle", 8'h00, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_uart_transmitter_controller
`default_nettype wire
